// File: rtl/seg_pkg.sv
// seg_pkg: shared segment pattern constants, FSM state type and defaults for the scan decoder
package seg_pkg;

  localparam int NUM_DIGITS_DEF = 4;

  // Active-low seven-segment patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] PAT_0 = 7'b1000000;
  localparam logic [6:0] PAT_1 = 7'b1111001;
  localparam logic [6:0] PAT_2 = 7'b0100100;
  localparam logic [6:0] PAT_3 = 7'b0110000;
  localparam logic [6:0] PAT_4 = 7'b0011001;
  localparam logic [6:0] PAT_5 = 7'b0010010;
  localparam logic [6:0] PAT_6 = 7'b0000010;
  localparam logic [6:0] PAT_7 = 7'b1011000;
  localparam logic [6:0] PAT_8 = 7'b0000000;
  localparam logic [6:0] PAT_9 = 7'b0010000;

  typedef enum logic {
    SETTLING = 1'b0,
    CAPTURED = 1'b1
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low 7-segment pattern to its decimal value and a legality flag
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] value,
  output logic       legal
);

  // Only the ten decimal glyphs are legal; anything else reports illegal with value 0
  always_comb begin
    value = 4'd0;
    legal = 1'b1;
    case (pat)
      PAT_0:   value = 4'd0;
      PAT_1:   value = 4'd1;
      PAT_2:   value = 4'd2;
      PAT_3:   value = 4'd3;
      PAT_4:   value = 4'd4;
      PAT_5:   value = 4'd5;
      PAT_6:   value = 4'd6;
      PAT_7:   value = 4'd7;
      PAT_8:   value = 4'd8;
      PAT_9:   value = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment display bus and recovers the shown digits
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err
);

  localparam int         W    = 8 + NUM_DIGITS;
  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);

  logic [W-1:0]              meta_q, s_q;
  logic [7:0]                seg_s;
  logic [NUM_DIGITS-1:0]     an_s, en;
  logic                      chg, one_hot, capture;
  logic [7:0]                cnt_q, cnt_d;
  state_t                    state_q, state_d;
  logic [3:0]                dec_val;
  logic                      dec_legal;
  logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0]     dp_q, dp_d, valid_q, valid_d, seen_q, seen_d, seen_nxt;
  logic                      err_q, err_d, frame_q, frame_d;

  // Two-flop synchroniser for the whole pin bundle; idle bus (all ones) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      s_q    <= '1;
    end else begin
      meta_q <= {an_n, seg_n};
      s_q    <= meta_q;
    end
  end

  assign {an_s, seg_s} = s_q;
  // s is about to take a new value on the coming edge, so the count restarts with it
  assign chg = meta_q != s_q;
  assign en  = ~an_s;
  assign one_hot = (en != '0) && ((en & (en - NUM_DIGITS'(1))) == '0);

  // Stability counter: restarts on a change of s, saturates once the value is settled
  always_comb begin
    cnt_d = chg ? 8'd0 : (cnt_q == CMAX ? cnt_q : cnt_q + 8'd1);
  end

  // FSM state register together with the stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLING;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any change returns to settling; a full stable run captures once
  always_comb begin
    state_d = chg ? SETTLING : (state_q == SETTLING && cnt_q == CMAX - 8'd1) ? CAPTURED : state_q;
  end

  // FSM output: the single capture event of a settled value
  always_comb begin
    capture = state_q == SETTLING && !chg && cnt_q == CMAX - 8'd1;
  end

  seg_pattern_decode u_dec (
    .pat   (seg_s[6:0]),
    .value (dec_val),
    .legal (dec_legal)
  );

  // Per-position update on capture, plus error and end-of-frame detection
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    seen_nxt = seen_q;
    err_d    = 1'b0;
    if (capture && one_hot) begin
      err_d = !dec_legal;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (en[k]) begin
          seen_nxt[k] = 1'b1;
          valid_d[k]  = dec_legal;
          digits_d[4*k +: 4] = dec_legal ? dec_val : digits_q[4*k +: 4];
          dp_d[k]     = dec_legal ? ~seg_s[7] : dp_q[k];
        end
      end
    end else if (capture && en != '0) begin
      err_d = 1'b1;
    end
    frame_d = capture && (&seen_nxt);
    seen_d  = frame_d ? '0 : seen_nxt;
  end

  // Registered outputs and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      dp_q     <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err         = err_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4, is the number of multiplexed digit positions (range 1..8).
REQ-002 Parameter STABLE_CYCLES, default 4, is the consecutive identical samples needed before capture (range 2..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 seg_n  input  8  segment lines, active-low; bit7 = DP, bit6 = g ... bit0 = a; asynchronous to clk.
REQ-006 an_n  input  NUM_DIGITS  digit enables, active-low; bit k selects position k; asynchronous to clk.
REQ-007 digits  output  4*NUM_DIGITS  decoded value per position; position k at [4k+3:4k].
REQ-008 dp  output  NUM_DIGITS  decimal point lit per position (1 = lit).
REQ-009 digit_valid  output  NUM_DIGITS  1 = position holds a legal decoded pattern.
REQ-010 frame_valid  output  1  one-cycle pulse when every position has been captured since the last pulse.
REQ-011 err  output  1  one-cycle pulse on an illegal pattern or an illegal enable combination.

Function
REQ-012 seg_n and an_n SHALL each pass through a 2-flop synchroniser; the second stage (s) feeds all logic.
REQ-013 FSM states: SETTLING, CAPTURED.
REQ-014 stable_cnt SHALL clear to 0 on any cycle s differs from its previous-cycle value and increment, saturating at STABLE_CYCLES, otherwise.
REQ-015 SETTLING -> CAPTURED when stable_cnt reaches STABLE_CYCLES-1 with s unchanged; a capture event fires in that cycle.
REQ-016 CAPTURED -> SETTLING on any change of s; no further capture until the new value is stable.
REQ-017 Pin-to-output latency SHALL be exactly 2 + STABLE_CYCLES cycles for an input held constant throughout.
REQ-018 Legal patterns for seg_n[6:0] -> value: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1011000->7, 0000000->8, 0010000->9.
REQ-019 Capture with exactly one an_n bit k low and a legal pattern: digits[k] <= value, dp[k] <= ~seg_n[7], digit_valid[k] <= 1, seen[k] <= 1.
REQ-020 Capture with exactly one an_n bit k low and an illegal pattern: err pulses, digit_valid[k] <= 0, digits[k] and dp[k] unchanged, seen[k] <= 1.
REQ-021 Capture with an_n all ones (blanking): no register change, no err.
REQ-022 Capture with two or more an_n bits low: err pulses, no per-position register change.
REQ-023 When seen, including the current capture, is all ones: frame_valid pulses in the cycle after capture and seen clears to 0.
REQ-024 err and frame_valid SHALL be registered, never both driven from the same stale capture.

Reset
REQ-025 On rst_n low: synchroniser stages = all ones, state = SETTLING, stable_cnt = 0, seen = 0.
REQ-026 Reset values: digits = 0, dp = 0, digit_valid = 0, frame_valid = 0, err = 0.
REQ-027 Reset mid-settle or mid-frame SHALL discard partial counts and seen bits; the first capture after release requires the full 2 + STABLE_CYCLES latency.

Structure
REQ-028 Shared package seg_pkg SHALL hold the ten legal segment pattern constants, the FSM state enum and the NUM_DIGITS default.
REQ-029 Sub-module seg_pattern_decode (combinational, 7-bit pattern -> 4-bit value + legal flag) SHALL implement REQ-018.

Verification
REQ-030 Positions 0..3 driven in turn with 2,0,2,4 (patterns per REQ-018, DP off), 10 cycles each -> digits = 0x4202, digit_valid = 4'b1111, one frame_valid pulse.
REQ-031 an_n = 4'b1110, seg_n = 8'b0_1011000 held -> digits[3:0] = 7, dp[0] = 1 exactly 6 cycles after the pin change.
REQ-032 seg_n toggled every 3 cycles with STABLE_CYCLES = 4 -> no capture, no err, outputs unchanged.
REQ-033 an_n = 4'b1101, seg_n = 8'b11111111 stable -> err single pulse, digit_valid[1] = 0; then an_n = 4'b1100 -> second err pulse, no register change.
REQ-034 an_n = 4'b1111 with any seg_n for 20 cycles -> no err, no frame_valid, no register change.
REQ-035 rst_n pulsed low after positions 0..2 captured -> all outputs zero; position 3 alone then produces no frame_valid.
